// File: rtl/uart_fifo_param_pkg.sv
// Shared types and helpers for the parametrised UART FIFO.
// Pointer wrap rule and per-cycle operation decode live here so top and tests agree on them.
package uart_fifo_param_pkg;

   typedef enum logic [1:0] {
      FIFO_IDLE,
      FIFO_PUSH,
      FIFO_POP,
      FIFO_BOTH
   } fifo_op_e;

   // Widest pointer needed for the largest supported depth (256 entries).
   localparam int PTR_MAX_W = 8;

   // Wrap by explicit compare so non-power-of-two depths work.
   function automatic logic [PTR_MAX_W-1:0] next_ptr(input logic [PTR_MAX_W-1:0] ptr,
                                                     input int depth);
      logic [PTR_MAX_W-1:0] nxt;
      if (32'(ptr) == 32'(depth - 1)) begin
         nxt = '0;
      end else begin
         nxt = ptr + PTR_MAX_W'(1);
      end
      return nxt;
   endfunction

   // A pop on empty is ignored even when paired with a push; a push on full
   // only proceeds when a pop frees the slot in the same cycle.
   function automatic fifo_op_e decode_op(input logic push,
                                          input logic pop,
                                          input logic full,
                                          input logic empty);
      fifo_op_e op;
      op = FIFO_IDLE;
      if (push && pop) begin
         op = empty ? FIFO_PUSH : FIFO_BOTH;
      end else if (push) begin
         op = full ? FIFO_IDLE : FIFO_PUSH;
      end else if (pop) begin
         op = empty ? FIFO_IDLE : FIFO_POP;
      end
      return op;
   endfunction

endpackage

// File: rtl/uart_fifo_param_if.sv
// Push/pop, threshold and status bundle between the APB register block and the FIFO.
// master drives commands and thresholds; slave is the FIFO returning data and status.
interface uart_fifo_param_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH + 1);

   logic             flush;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] data_in;
   logic [CW-1:0]    af_thresh;
   logic [CW-1:0]    ae_thresh;

   logic [WIDTH-1:0] data_out;
   logic             fifo_empty;
   logic             fifo_full;
   logic             almost_full;
   logic             almost_empty;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             underflow;

   modport master (
      output flush, push, pop, data_in, af_thresh, ae_thresh,
      input  data_out, fifo_empty, fifo_full, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  flush, push, pop, data_in, af_thresh, ae_thresh,
      output data_out, fifo_empty, fifo_full, almost_full, almost_empty,
             count, overflow, underflow
   );

endinterface

// File: rtl/uart_fifo_param_mem.sv
// FIFO storage: register array, synchronous write, asynchronous read, no reset on contents.
// Read data follows raddr combinationally; a write lands on the rising edge.
module uart_fifo_param_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_fifo_param.sv
// Parametrised first-word-fall-through FIFO for the UART TX/RX paths; zero read latency.
// No backpressure: pushes while full are dropped (overflow), pops while empty ignored (underflow).
module uart_fifo_param
   import uart_fifo_param_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic            clk,
   input  logic            rst,
   uart_fifo_param_if.slave bus
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic             overflow_q;
   logic             underflow_q;

   logic             empty;
   logic             full;
   fifo_op_e         op;
   logic             do_push;
   logic             do_pop;
   logic             ovf_evt;
   logic             unf_evt;
   logic [WIDTH-1:0] rd_dat;

   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_LVL);

   always_comb begin
      op      = decode_op(bus.push, bus.pop, full, empty);
      do_push = 1'b0;
      do_pop  = 1'b0;
      if (!bus.flush) begin
         do_push = (op == FIFO_PUSH) || (op == FIFO_BOTH);
         do_pop  = (op == FIFO_POP)  || (op == FIFO_BOTH);
      end
   end

   // A push paired with a pop at full is not an overflow: the pop makes room.
   assign ovf_evt = bus.push && !bus.pop && full;
   assign unf_evt = bus.pop && empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (bus.flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr <= PW'(next_ptr(PTR_MAX_W'(wr_ptr), DEPTH));
         end
         if (do_pop) begin
            rd_ptr <= PW'(next_ptr(PTR_MAX_W'(rd_ptr), DEPTH));
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (ovf_evt) begin
            overflow_q <= 1'b1;
         end
         if (unf_evt) begin
            underflow_q <= 1'b1;
         end
      end
   end

   uart_fifo_param_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (do_push),
      .waddr (wr_ptr),
      .wdata (bus.data_in),
      .raddr (rd_ptr),
      .rdata (rd_dat)
   );

   // Storage is never reset, so the head is masked to zero while empty.
   assign bus.data_out     = empty ? '0 : rd_dat;
   assign bus.fifo_empty   = empty;
   assign bus.fifo_full    = full;
   assign bus.almost_full  = (count_q >= bus.af_thresh);
   assign bus.almost_empty = (count_q <= bus.ae_thresh);
   assign bus.count        = count_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_uart_fifo_param.sv
// Bench for uart_fifo_param: DEPTH=16 and DEPTH=12 instances against a queue-based reference.
module tb_uart_fifo_param;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_fifo_param_if #(.WIDTH(8), .DEPTH(16)) ia ();
   uart_fifo_param_if #(.WIDTH(8), .DEPTH(12)) ib ();

   uart_fifo_param #(.WIDTH(8), .DEPTH(16)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
   uart_fifo_param #(.WIDTH(8), .DEPTH(12)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Reference model: a queue per instance plus sticky error bits.
   logic [7:0] mq [2][$];
   bit         m_ovf [2];
   bit         m_unf [2];
   int         depth_of [2] = '{16, 12};

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         mq[d].delete();
         m_ovf[d] = 1'b0;
         m_unf[d] = 1'b0;
      end
   endtask

   task automatic model_step(input int d, input bit fl, input bit ps, input bit pp,
                             input logic [7:0] din);
      int n;
      n = mq[d].size();
      if (fl) begin
         mq[d].delete();
         m_ovf[d] = 1'b0;
         m_unf[d] = 1'b0;
      end else begin
         if (pp && n == 0) m_unf[d] = 1'b1;
         if (ps && !pp && n == depth_of[d]) m_ovf[d] = 1'b1;
         if (pp && n > 0) void'(mq[d].pop_front());
         if (ps && (n < depth_of[d] || pp)) mq[d].push_back(din);
      end
   endtask

   task automatic chk_model(input int d);
      int n;
      logic [31:0] cnt, dout, aft, aet;
      logic e, f, af, ae, ov, un;
      string p;
      n = mq[d].size();
      if (d == 0) begin
         p = "a"; cnt = 32'(ia.count); dout = 32'(ia.data_out);
         aft = 32'(ia.af_thresh); aet = 32'(ia.ae_thresh);
         e = ia.fifo_empty; f = ia.fifo_full; af = ia.almost_full; ae = ia.almost_empty;
         ov = ia.overflow; un = ia.underflow;
      end else begin
         p = "b"; cnt = 32'(ib.count); dout = 32'(ib.data_out);
         aft = 32'(ib.af_thresh); aet = 32'(ib.ae_thresh);
         e = ib.fifo_empty; f = ib.fifo_full; af = ib.almost_full; ae = ib.almost_empty;
         ov = ib.overflow; un = ib.underflow;
      end
      chk({p, ".count"}, cnt, 32'(n));
      chk({p, ".data_out"}, dout, (n > 0) ? 32'(mq[d][0]) : 32'd0);
      chk({p, ".empty"}, 32'(e), 32'(n == 0));
      chk({p, ".full"}, 32'(f), 32'(n == depth_of[d]));
      chk({p, ".almost_full"}, 32'(af), 32'(32'(n) >= aft));
      chk({p, ".almost_empty"}, 32'(ae), 32'(32'(n) <= aet));
      chk({p, ".overflow"}, 32'(ov), 32'(m_ovf[d]));
      chk({p, ".underflow"}, 32'(un), 32'(m_unf[d]));
   endtask

   // One clock: model follows the inputs held across the edge, outputs sampled 1 later.
   task automatic tick();
      @(posedge clk);
      model_step(0, ia.flush, ia.push, ia.pop, ia.data_in);
      model_step(1, ib.flush, ib.push, ib.pop, ib.data_in);
      #1;
      chk_model(0);
      chk_model(1);
   endtask

   task automatic set_a(input bit ps, input bit pp, input logic [7:0] din, input bit fl);
      ia.push = ps; ia.pop = pp; ia.data_in = din; ia.flush = fl;
   endtask

   task automatic set_b(input bit ps, input bit pp, input logic [7:0] din, input bit fl);
      ib.push = ps; ib.pop = pp; ib.data_in = din; ib.flush = fl;
   endtask

   typedef struct {
      bit         ps;
      bit         pp;
      bit         fl;
      logic [7:0] din;
      int         cnt;
      bit         emp;
      logic [7:0] dout;
      bit         unf;
   } vec_t;

   vec_t tbl [10];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h5A, 1, 1'b0, 8'h5A, 1'b1};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 8'h11, 2, 1'b0, 8'h5A, 1'b1};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b0, 8'h11, 1'b1};
      tbl[3] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 8'h00, 1'b1};
      tbl[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 8'h00, 1'b1};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h00, 1'b0};
      tbl[6] = '{1'b0, 1'b1, 1'b1, 8'h00, 0, 1'b1, 8'h00, 1'b0};
      tbl[7] = '{1'b1, 1'b0, 1'b1, 8'h22, 0, 1'b1, 8'h00, 1'b0};
      tbl[8] = '{1'b1, 1'b0, 1'b0, 8'h33, 1, 1'b0, 8'h33, 1'b0};
      tbl[9] = '{1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0, 8'h33, 1'b0};

      rst = 1'b1;
      set_a(0, 0, 8'h00, 0);
      set_b(0, 0, 8'h00, 0);
      ia.af_thresh = 5'd12; ia.ae_thresh = 5'd3;
      ib.af_thresh = 4'd10; ib.ae_thresh = 4'd2;
      model_reset();
      #12;
      rst = 1'b0;
      chk("rst.empty", 32'(ia.fifo_empty), 1);
      chk("rst.full", 32'(ia.fifo_full), 0);
      chk("rst.count", 32'(ia.count), 0);
      chk("rst.data_out", 32'(ia.data_out), 0);
      chk("rst.overflow", 32'(ia.overflow), 0);
      chk("rst.underflow", 32'(ia.underflow), 0);

      // Fill 00..0F, then drain in order.
      for (int i = 0; i < 16; i++) begin set_a(1, 0, 8'(i), 0); tick(); end
      set_a(0, 0, 8'h00, 0);
      chk("t1.full", 32'(ia.fifo_full), 1);
      chk("t1.count", 32'(ia.count), 16);
      ia.ae_thresh = 5'd16; #1;
      chk("thr.ae_ge_depth", 32'(ia.almost_empty), 1);
      ia.ae_thresh = 5'd3; #1;
      for (int i = 0; i < 16; i++) begin
         chk("t1.pop_data", 32'(ia.data_out), 32'(i));
         set_a(0, 1, 8'h00, 0); tick();
      end
      set_a(0, 0, 8'h00, 0);
      chk("t1.empty", 32'(ia.fifo_empty), 1);
      ia.af_thresh = 5'd0; #1;
      chk("thr.af_zero", 32'(ia.almost_full), 1);
      ia.af_thresh = 5'd12; #1;

      // Overflow at full, order preserved, flush clears.
      for (int i = 0; i < 16; i++) begin set_a(1, 0, 8'(i), 0); tick(); end
      set_a(1, 0, 8'hAA, 0); tick();
      set_a(0, 0, 8'h00, 0);
      chk("t2.count", 32'(ia.count), 16);
      chk("t2.overflow", 32'(ia.overflow), 1);
      for (int i = 0; i < 16; i++) begin
         chk("t2.pop_data", 32'(ia.data_out), 32'(i));
         set_a(0, 1, 8'h00, 0); tick();
      end
      set_a(0, 0, 8'h00, 1); tick();
      set_a(0, 0, 8'h00, 0);
      chk("t2.flush_count", 32'(ia.count), 0);
      chk("t2.flush_overflow", 32'(ia.overflow), 0);

      // Directed vector table from empty.
      foreach (tbl[i]) begin
         set_a(tbl[i].ps, tbl[i].pp, tbl[i].din, tbl[i].fl);
         tick();
         chk($sformatf("tbl[%0d].count", i), 32'(ia.count), 32'(tbl[i].cnt));
         chk($sformatf("tbl[%0d].empty", i), 32'(ia.fifo_empty), 32'(tbl[i].emp));
         chk($sformatf("tbl[%0d].data_out", i), 32'(ia.data_out), 32'(tbl[i].dout));
         chk($sformatf("tbl[%0d].underflow", i), 32'(ia.underflow), 32'(tbl[i].unf));
      end

      // Push & pop at full: level holds, head advances by one.
      for (int i = 0; i < 15; i++) begin set_a(1, 0, 8'(8'h40 + i), 0); tick(); end
      set_a(0, 0, 8'h00, 0);
      chk("t3.full_head", 32'(ia.data_out), 32'h33);
      set_a(1, 1, 8'h99, 0); tick();
      set_a(0, 0, 8'h00, 0);
      chk("t3.both_full_count", 32'(ia.count), 16);
      chk("t3.both_full_head", 32'(ia.data_out), 32'h40);
      chk("t3.both_full_ovf", 32'(ia.overflow), 0);
      set_a(0, 0, 8'h00, 1); tick();
      set_a(0, 0, 8'h00, 0);

      // DEPTH=12: one entry pre-loaded, 30 pairs cross the wrap twice.
      set_b(1, 0, 8'h00, 0); tick();
      for (int i = 1; i <= 30; i++) begin
         set_b(1, 1, 8'(i), 0); tick();
         chk("t4.count", 32'(ib.count), 1);
         chk("t4.data", 32'(ib.data_out), 32'(i));
      end
      set_b(0, 0, 8'h00, 1); tick();
      set_b(0, 0, 8'h00, 0);

      // Threshold edges with af=12, ae=3.
      for (int k = 1; k <= 12; k++) begin
         set_a(1, 0, 8'(k), 0); tick();
         chk($sformatf("t5.af_push%0d", k), 32'(ia.almost_full), 32'(k >= 12));
         chk($sformatf("t5.ae_push%0d", k), 32'(ia.almost_empty), 32'(k <= 3));
      end
      set_a(0, 0, 8'h00, 1); tick();

      // Asynchronous reset between edges at count 7, push still asserted.
      set_a(0, 1, 8'h00, 0); tick();
      for (int i = 0; i < 7; i++) begin set_a(1, 0, 8'(8'h70 + i), 0); tick(); end
      set_a(1, 0, 8'hEE, 0);
      chk("t6.pre_count", 32'(ia.count), 7);
      chk("t6.pre_underflow", 32'(ia.underflow), 1);
      #2 rst = 1'b1;
      #1 rst = 1'b0;
      model_reset();
      #1;
      chk("t6.count", 32'(ia.count), 0);
      chk("t6.empty", 32'(ia.fifo_empty), 1);
      chk("t6.full", 32'(ia.fifo_full), 0);
      chk("t6.data_out", 32'(ia.data_out), 0);
      chk("t6.underflow", 32'(ia.underflow), 0);
      chk("t6.overflow", 32'(ia.overflow), 0);
      set_a(0, 0, 8'h00, 0);
      tick();

      // Randomised traffic on both instances: fill-biased, then drain-biased.
      for (int c = 0; c < 400; c++) begin
         int bias;
         bias = (c < 200) ? 70 : 30;
         if (c % 50 == 0) begin
            ia.af_thresh = 5'($urandom_range(0, 31));
            ia.ae_thresh = 5'($urandom_range(0, 31));
            ib.af_thresh = 4'($urandom_range(0, 15));
            ib.ae_thresh = 4'($urandom_range(0, 15));
         end
         set_a($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias,
               8'($urandom), $urandom_range(0, 79) == 0);
         set_b($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias,
               8'($urandom), $urandom_range(0, 79) == 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
